// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - iterative round sequencer for a shared AES round unit; optional AES_ABORT_EN adds an abort input
module aes_round_sched #(
    parameter int NR    = 10,
    parameter int KEY_W = 128*(NR+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [127:0]     data_in,
    input  logic [0:KEY_W-1] expanded_key,
`ifdef AES_ABORT_EN
    input  logic             abort,
`endif
    output logic [127:0]     rnd_state,
    output logic [127:0]     rnd_key,
    output logic [1:0]       rnd_kind,
    output logic             rnd_mode,
    input  logic [127:0]     rnd_result,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [127:0]     data_out
);

    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t       fsm;
    state_t       fsm_nxt;
    logic [3:0]   cnt;
    logic [127:0] st_q;
    logic         mode_q;
    logic [3:0]   key_idx;
    logic         last_rnd;
    logic         accept;
    logic         abort_req;
    logic [127:0] round_keys [0:NR];

    // Round key r sits at bit offset 128*r of the expansion bus
    for (genvar r = 0; r <= NR; r++) begin : g_key
        assign round_keys[r] = expanded_key[128*r +: 128];
    end

`ifdef AES_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign ready    = (fsm == S_IDLE) || (fsm == S_DONE);
    assign busy     = (fsm == S_RUN);
    assign done     = (fsm == S_DONE);
    assign accept   = start & ready;
    assign last_rnd = (cnt == LAST);
    // Decryption walks the key schedule backwards
    assign key_idx  = mode_q ? (LAST - cnt) : cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm <= S_IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state logic; abort wins over completion on the last round
    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE: if (start) fsm_nxt = S_RUN;
            S_RUN: begin
                if (abort_req) begin
                    fsm_nxt = S_IDLE;
                end else if (last_rnd) begin
                    fsm_nxt = S_DONE;
                end
            end
            S_DONE:  fsm_nxt = start ? S_RUN : S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase
    end

    // Cipher state, round counter and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= 4'd0;
            st_q     <= 128'd0;
            mode_q   <= 1'b0;
            data_out <= 128'd0;
        end else if (accept) begin
            st_q   <= data_in;
            mode_q <= mode;
            cnt    <= 4'd0;
        end else if (fsm == S_RUN) begin
            if (abort_req) begin
                cnt <= 4'd0;
            end else begin
                st_q <= rnd_result;
                if (last_rnd) begin
                    data_out <= rnd_result;
                    cnt      <= 4'd0;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    // Round unit drive; key and kind are only meaningful while running
    always_comb begin
        rnd_state = st_q;
        rnd_mode  = mode_q;
        rnd_key   = 128'd0;
        rnd_kind  = 2'd0;
        if (fsm == S_RUN) begin
            rnd_key = round_keys[key_idx];
            if (cnt == 4'd0) begin
                rnd_kind = 2'd0;
            end else if (last_rnd) begin
                rnd_kind = 2'd2;
            end else begin
                rnd_kind = 2'd1;
            end
        end
    end

endmodule
